cu_pipe: RTL and testbench

//  Registered RV32I(+optional M) decode/control stage for the pipelined core. Decodes instr_i in ID, registers the

---
 rtl/cu_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_cu_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_pipe.sv
// cu_pipe: RV32I(+M) decode/control stage. Registers the ID decode into EX,
// sequences multi-cycle mul/div by stalling ID, and delays write-back controls to WB.
module cu_pipe #(
    parameter bit M_EXT      = 1'b1,
    parameter int MD_LATENCY = 4,
    parameter int WB_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        id_stall_o,
    output logic        ex_valid_o,
    output logic        ex_reg_write_o,
    output logic        ex_mem_write_o,
    output logic        ex_mem_read_o,
    output logic [2:0]  ex_mem_size_o,
    output logic        ex_jump_o,
    output logic        ex_jalr_o,
    output logic        ex_branch_o,
    output logic [2:0]  ex_branch_type_o,
    output logic [1:0]  ex_result_src_o,
    output logic        ex_alu_src_o,
    output logic        ex_alu_src_a_pc_o,
    output logic [2:0]  ex_imm_src_o,
    output logic [3:0]  ex_alu_ctrl_o,
    output logic        ex_muldiv_o,
    output logic        ex_illegal_o,
    output logic        wb_reg_write_o,
    output logic [1:0]  wb_result_src_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [2:0] mem_size;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [2:0] branch_type;
        logic [1:0] result_src;
        logic       alu_src;
        logic       alu_src_a_pc;
        logic [2:0] imm_src;
        logic [3:0] alu_ctrl;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
    typedef logic [WB_STAGES-1:0][2:0] wb_line_t;

    function automatic wb_line_t wb_shift(input wb_line_t line, input logic [2:0] din);
        wb_line_t nxt;
        nxt[0] = din;
        for (int i = 1; i < WB_STAGES; i++) begin
            nxt[i] = line[i-1];
        end
        return nxt;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    ctrl_t      ex_d, ex_q;
    wb_line_t   wb_d, wb_q;
    md_state_e  md_state_q;
    logic [CNT_W-1:0] md_cnt_q;
    logic       id_stall_q;
    logic       md_hold;
    logic [2:0] wb_in;

    always_comb begin
        ex_d = '0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    ex_d.reg_write = 1'b1;
                    ex_d.alu_ctrl  = {funct7[5], funct3};
                end else if (M_EXT && funct7 == 7'b0000001) begin
                    ex_d.reg_write = 1'b1;
                    ex_d.muldiv    = 1'b1;
                    ex_d.alu_ctrl  = {1'b0, funct3};
                end else begin
                    ex_d.illegal = 1'b1;
                end
            end
            OP_I_ALU: begin
                ex_d.reg_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                // only srai carries the arithmetic bit; other immediates reuse funct7 bits as data
                ex_d.alu_ctrl  = {funct7[5] & (funct3 == 3'b101), funct3};
            end
            OP_LOAD: begin
                ex_d.reg_write  = 1'b1;
                ex_d.mem_read   = 1'b1;
                ex_d.alu_src    = 1'b1;
                ex_d.result_src = 2'b01;
                ex_d.mem_size   = funct3;
            end
            OP_STORE: begin
                ex_d.mem_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                ex_d.imm_src   = 3'b001;
                ex_d.mem_size  = funct3;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    ex_d.illegal = 1'b1;
                end else begin
                    ex_d.branch      = 1'b1;
                    ex_d.branch_type = funct3;
                    ex_d.imm_src     = 3'b010;
                    ex_d.alu_ctrl    = 4'b1000;
                end
            end
            OP_JAL: begin
                ex_d.reg_write  = 1'b1;
                ex_d.jump       = 1'b1;
                ex_d.result_src = 2'b10;
                ex_d.imm_src    = 3'b011;
            end
            OP_JALR: begin
                ex_d.reg_write  = 1'b1;
                ex_d.jump       = 1'b1;
                ex_d.jalr       = 1'b1;
                ex_d.alu_src    = 1'b1;
                ex_d.result_src = 2'b10;
            end
            OP_LUI: begin
                ex_d.reg_write  = 1'b1;
                ex_d.result_src = 2'b11;
                ex_d.imm_src    = 3'b100;
            end
            OP_AUIPC: begin
                ex_d.reg_write    = 1'b1;
                ex_d.alu_src_a_pc = 1'b1;
                ex_d.alu_src      = 1'b1;
                ex_d.imm_src      = 3'b100;
            end
            default: ex_d.illegal = 1'b1;
        endcase
        if (ex_d.illegal) begin
            ex_d         = '0;
            ex_d.illegal = 1'b1;
        end
        ex_d.valid = 1'b1;
        if (!instr_valid_i) begin
            ex_d = '0;
        end
    end

    // A mul/div keeps EX while its countdown is non-zero; the WB line sees bubbles meanwhile.
    assign md_hold = (md_state_q == MD_BUSY) && (md_cnt_q != '0);
    assign wb_in   = md_hold ? 3'b000 : {ex_q.valid & ex_q.reg_write, ex_q.result_src};
    assign wb_d    = wb_shift(wb_q, wb_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            wb_q       <= '0;
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
            id_stall_q <= 1'b0;
        end else if (flush_i) begin
            ex_q       <= '0;
            wb_q       <= wb_d;
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
            id_stall_q <= 1'b0;
        end else if (!stall_i) begin
            wb_q <= wb_d;
            if (md_hold) begin
                md_cnt_q <= md_cnt_q - CNT_W'(1);
            end else begin
                ex_q <= ex_d;
                if (ex_d.muldiv && MD_LATENCY > 1) begin
                    md_state_q <= MD_BUSY;
                    md_cnt_q   <= CNT_W'(MD_LATENCY - 1);
                    id_stall_q <= 1'b1;
                end else begin
                    md_state_q <= MD_IDLE;
                    md_cnt_q   <= '0;
                    id_stall_q <= 1'b0;
                end
            end
        end
    end

    assign id_stall_o        = id_stall_q;
    assign ex_valid_o        = ex_q.valid;
    assign ex_reg_write_o    = ex_q.reg_write;
    assign ex_mem_write_o    = ex_q.mem_write;
    assign ex_mem_read_o     = ex_q.mem_read;
    assign ex_mem_size_o     = ex_q.mem_size;
    assign ex_jump_o         = ex_q.jump;
    assign ex_jalr_o         = ex_q.jalr;
    assign ex_branch_o       = ex_q.branch;
    assign ex_branch_type_o  = ex_q.branch_type;
    assign ex_result_src_o   = ex_q.result_src;
    assign ex_alu_src_o      = ex_q.alu_src;
    assign ex_alu_src_a_pc_o = ex_q.alu_src_a_pc;
    assign ex_imm_src_o      = ex_q.imm_src;
    assign ex_alu_ctrl_o     = ex_q.alu_ctrl;
    assign ex_muldiv_o       = ex_q.muldiv;
    assign ex_illegal_o      = ex_q.illegal;
    assign wb_reg_write_o    = wb_q[WB_STAGES-1][2];
    assign wb_result_src_o   = wb_q[WB_STAGES-1][1:0];

endmodule

// File: tb/tb_cu_pipe.sv
// Bench for cu_pipe: directed scenarios plus random instruction streams against a
// behavioural model of the decode stage, mul/div occupancy and write-back delay.
module tb_cu_pipe;

    localparam int MD_LAT = 4;
    localparam int WB_N   = 2;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_SUB   = 32'h403100B3;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
    localparam logic [31:0] I_DIV   = 32'h0220C0B3;
    localparam logic [31:0] I_AUIPC = 32'h00001097;

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mw;
        logic       mr;
        logic [2:0] msz;
        logic       jmp;
        logic       jalr;
        logic       br;
        logic [2:0] bt;
        logic [1:0] rs;
        logic       asrc;
        logic       apc;
        logic [2:0] imm;
        logic [3:0] ctrl;
        logic       md;
        logic       ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic        instr_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;

    logic        id_stall_o, ex_valid_o, ex_reg_write_o, ex_mem_write_o, ex_mem_read_o;
    logic [2:0]  ex_mem_size_o, ex_branch_type_o, ex_imm_src_o;
    logic        ex_jump_o, ex_jalr_o, ex_branch_o, ex_alu_src_o, ex_alu_src_a_pc_o;
    logic [1:0]  ex_result_src_o, wb_result_src_o;
    logic [3:0]  ex_alu_ctrl_o;
    logic        ex_muldiv_o, ex_illegal_o, wb_reg_write_o;

    logic        n_id_stall_o, n_ex_valid_o, n_ex_reg_write_o, n_ex_mem_write_o, n_ex_mem_read_o;
    logic [2:0]  n_ex_mem_size_o, n_ex_branch_type_o, n_ex_imm_src_o;
    logic        n_ex_jump_o, n_ex_jalr_o, n_ex_branch_o, n_ex_alu_src_o, n_ex_alu_src_a_pc_o;
    logic [1:0]  n_ex_result_src_o, n_wb_result_src_o;
    logic [3:0]  n_ex_alu_ctrl_o;
    logic        n_ex_muldiv_o, n_ex_illegal_o, n_wb_reg_write_o;

    always #5 clk = ~clk;

    cu_pipe #(.M_EXT(1'b1), .MD_LATENCY(MD_LAT), .WB_STAGES(WB_N)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .id_stall_o(id_stall_o),
        .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_size_o(ex_mem_size_o), .ex_jump_o(ex_jump_o), .ex_jalr_o(ex_jalr_o),
        .ex_branch_o(ex_branch_o), .ex_branch_type_o(ex_branch_type_o),
        .ex_result_src_o(ex_result_src_o), .ex_alu_src_o(ex_alu_src_o),
        .ex_alu_src_a_pc_o(ex_alu_src_a_pc_o), .ex_imm_src_o(ex_imm_src_o),
        .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_muldiv_o(ex_muldiv_o), .ex_illegal_o(ex_illegal_o),
        .wb_reg_write_o(wb_reg_write_o), .wb_result_src_o(wb_result_src_o)
    );

    cu_pipe #(.M_EXT(1'b0), .MD_LATENCY(MD_LAT), .WB_STAGES(WB_N)) dut_nom (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .id_stall_o(n_id_stall_o),
        .ex_valid_o(n_ex_valid_o), .ex_reg_write_o(n_ex_reg_write_o),
        .ex_mem_write_o(n_ex_mem_write_o), .ex_mem_read_o(n_ex_mem_read_o),
        .ex_mem_size_o(n_ex_mem_size_o), .ex_jump_o(n_ex_jump_o), .ex_jalr_o(n_ex_jalr_o),
        .ex_branch_o(n_ex_branch_o), .ex_branch_type_o(n_ex_branch_type_o),
        .ex_result_src_o(n_ex_result_src_o), .ex_alu_src_o(n_ex_alu_src_o),
        .ex_alu_src_a_pc_o(n_ex_alu_src_a_pc_o), .ex_imm_src_o(n_ex_imm_src_o),
        .ex_alu_ctrl_o(n_ex_alu_ctrl_o), .ex_muldiv_o(n_ex_muldiv_o), .ex_illegal_o(n_ex_illegal_o),
        .wb_reg_write_o(n_wb_reg_write_o), .wb_result_src_o(n_wb_result_src_o)
    );

    exp_t obs;
    assign obs = {ex_valid_o, ex_reg_write_o, ex_mem_write_o, ex_mem_read_o, ex_mem_size_o,
                  ex_jump_o, ex_jalr_o, ex_branch_o, ex_branch_type_o, ex_result_src_o,
                  ex_alu_src_o, ex_alu_src_a_pc_o, ex_imm_src_o, ex_alu_ctrl_o,
                  ex_muldiv_o, ex_illegal_o};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction in EX, how many cycles it has spent there,
    // and the write-back pipe as a fixed-length queue (front = oldest = WB output).
    exp_t       m_ex;
    int         m_spent;
    logic [2:0] m_wb[$];

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic v, input bit mext);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal;
        e = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        legal = 1'b1;
        if (!v) return '0;
        case (op)
            7'b0110011: begin
                if (f7 == 7'd0 || f7 == 7'd32) begin
                    e.rw = 1; e.ctrl = {f7[5], f3};
                end else if (mext && f7 == 7'd1) begin
                    e.rw = 1; e.md = 1; e.ctrl = {1'b0, f3};
                end else legal = 1'b0;
            end
            7'b0010011: begin e.rw = 1; e.asrc = 1; e.ctrl = {(f3 == 3'd5) ? f7[5] : 1'b0, f3}; end
            7'b0000011: begin e.rw = 1; e.mr = 1; e.asrc = 1; e.rs = 2'd1; e.msz = f3; end
            7'b0100011: begin e.mw = 1; e.asrc = 1; e.imm = 3'd1; e.msz = f3; end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
                else begin e.br = 1; e.bt = f3; e.imm = 3'd2; e.ctrl = 4'd8; end
            end
            7'b1101111: begin e.rw = 1; e.jmp = 1; e.rs = 2'd2; e.imm = 3'd3; end
            7'b1100111: begin e.rw = 1; e.jmp = 1; e.jalr = 1; e.asrc = 1; e.rs = 2'd2; end
            7'b0110111: begin e.rw = 1; e.rs = 2'd3; e.imm = 3'd4; end
            7'b0010111: begin e.rw = 1; e.apc = 1; e.asrc = 1; e.imm = 3'd4; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin e = '0; e.ill = 1; end
        e.valid = 1;
        return e;
    endfunction

    task automatic model_reset();
        m_ex = '0;
        m_spent = 0;
        m_wb.delete();
        for (int i = 0; i < WB_N; i++) m_wb.push_back(3'b000);
    endtask

    task automatic wb_push(input logic [2:0] v);
        m_wb.push_back(v);
        void'(m_wb.pop_front());
    endtask

    task automatic model_edge();
        bit owed;
        logic [2:0] leaving;
        owed = m_ex.md && (m_spent < MD_LAT);
        leaving = owed ? 3'b000 : {m_ex.valid & m_ex.rw, m_ex.rs};
        if (flush_i) begin
            wb_push(leaving);
            m_ex = '0;
            m_spent = 0;
        end else if (!stall_i) begin
            wb_push(leaving);
            if (owed) m_spent++;
            else begin
                m_ex = ref_decode(instr_i, instr_valid_i, 1'b1);
                m_spent = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ex_bundle", 32'(obs), 32'(m_ex));
        chk("wb_ctrl", 32'({wb_reg_write_o, wb_result_src_o}), 32'(m_wb[0]));
        chk("id_stall", 32'(id_stall_o), 32'(m_ex.md && MD_LAT > 1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex"}, 32'(obs), 32'd0);
        chk({tag, "_wb"}, 32'({wb_reg_write_o, wb_result_src_o}), 32'd0);
        chk({tag, "_stall"}, 32'(id_stall_o), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 11);
        case (k)
            0: begin r[6:0] = 7'b0110011; r[31:25] = r[30] ? 7'h20 : 7'h00; end
            1: begin r[6:0] = 7'b0110011; r[31:25] = 7'h01; end
            2: r[6:0] = 7'b0110011;
            3: r[6:0] = 7'b0010011;
            4: r[6:0] = 7'b0000011;
            5: r[6:0] = 7'b0100011;
            6: r[6:0] = 7'b1100011;
            7: r[6:0] = 7'b1101111;
            8: r[6:0] = 7'b1100111;
            9: r[6:0] = 7'b0110111;
            10: r[6:0] = 7'b0010111;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        model_reset();
        #2;
        chk_all_zero("reset");
        #1 rst_n = 1'b1;

        instr_valid_i = 1'b1;
        instr_i = I_ADD;
        step();
        chk("add_valid", 32'(ex_valid_o), 32'd1);
        chk("add_rw", 32'(ex_reg_write_o), 32'd1);
        chk("add_ctrl", 32'(ex_alu_ctrl_o), 32'h0);
        instr_i = I_SUB;
        step();
        chk("sub_ctrl", 32'(ex_alu_ctrl_o), 32'h8);
        chk("add_wb_early", 32'(wb_reg_write_o), 32'd0);
        instr_valid_i = 1'b0;
        step();
        chk("add_wb", 32'(wb_reg_write_o), 32'd1);

        instr_valid_i = 1'b1;
        instr_i = I_BNE;
        step();
        chk("bne_br", 32'(ex_branch_o), 32'd1);
        chk("bne_type", 32'(ex_branch_type_o), 32'h1);
        chk("bne_imm", 32'(ex_imm_src_o), 32'h2);
        chk("bne_rw", 32'(ex_reg_write_o), 32'd0);
        instr_i = I_BAD;
        step();
        chk("bad_ill", 32'(ex_illegal_o), 32'd1);
        chk("bad_en", 32'({ex_reg_write_o, ex_mem_write_o, ex_mem_read_o, ex_jump_o, ex_branch_o}), 32'd0);
        instr_i = I_AUIPC;
        step();
        chk("auipc_pc", 32'(ex_alu_src_a_pc_o), 32'd1);
        chk("auipc_asrc", 32'(ex_alu_src_o), 32'd1);
        chk("auipc_imm", 32'(ex_imm_src_o), 32'h4);
        chk("auipc_res", 32'(ex_result_src_o), 32'h0);

        instr_i = I_DIV;
        step();
        chk("nomext_ill", 32'(n_ex_illegal_o), 32'd1);
        chk("nomext_md", 32'(n_ex_muldiv_o), 32'd0);
        instr_i = I_ADD;
        for (int c = 2; c <= MD_LAT; c++) begin
            chk("div_md", 32'(ex_muldiv_o), 32'd1);
            chk("div_stall", 32'(id_stall_o), 32'd1);
            step();
        end
        chk("div_md_last", 32'(ex_muldiv_o), 32'd1);
        chk("div_stall_last", 32'(id_stall_o), 32'd1);
        step();
        chk("after_div_md", 32'(ex_muldiv_o), 32'd0);
        chk("after_div_stall", 32'(id_stall_o), 32'd0);
        chk("after_div_rw", 32'(ex_reg_write_o), 32'd1);

        instr_i = I_DIV;
        step();
        instr_i = I_SUB;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_valid", 32'(ex_valid_o), 32'd0);
        chk("flush_stall", 32'(id_stall_o), 32'd0);

        instr_i = I_ADD;
        step();
        stall_i = 1'b1;
        instr_i = I_BNE;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_br", 32'(ex_branch_o), 32'd0);
            chk("hold_rw", 32'(ex_reg_write_o), 32'd1);
        end
        stall_i = 1'b0;
        step();
        chk("unhold_br", 32'(ex_branch_o), 32'd1);

        instr_i = I_DIV;
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_busy");
        model_reset();
        #1 rst_n = 1'b1;
        instr_i = I_SUB;
        step();
        chk("post_rst_ctrl", 32'(ex_alu_ctrl_o), 32'h8);

        for (int n = 0; n < 900; n++) begin
            instr_i = rand_instr();
            instr_valid_i = ($urandom_range(0, 9) != 0);
            stall_i = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 14) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
